uart_cmd_receiver: RTL and testbench

UART_CMD_RECEIVER -- requirements
Module: uart_cmd_receiver

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/uart_bit_sampler.sv | 127 ++++++++++++
 rtl/uart_cmd_receiver.sv | 89 ++++++++
 tb/tb_uart_cmd_receiver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command receiver:
//   - rx_state_t      : receive FSM states (IDLE, START, DATA, STOP)
//   - CMD_TEMP_MOIST  : 'T' command byte (8'h54)
//   - CMD_DIST        : 'D' command byte (8'h44)
//   - CMD_CR          : carriage return (8'h0D)
//   - is_command()    : true for the bytes the optional filter lets through
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] CMD_TEMP_MOIST = 8'h54;
  localparam logic [7:0] CMD_DIST       = 8'h44;
  localparam logic [7:0] CMD_CR         = 8'h0D;

  function automatic logic is_command(input logic [7:0] b);
    return (b == CMD_TEMP_MOIST) || (b == CMD_DIST);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// ---------------------------------------------------------------------------
// uart_bit_sampler
// Recovers 8N1 bytes from an asynchronous serial line. The line is passed
// through a 2-flop synchronizer, the start bit is confirmed at its middle,
// and data/stop bits are then sampled once per bit period.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
// Ports:
//   clk         system clock, posedge
//   rst         asynchronous reset, active low
//   rxd         raw serial line (idle high, LSB first)
//   rx_byte     last assembled byte (valid together with frame_good)
//   frame_good  1-cycle strobe on the stop-bit sample cycle, stop bit high
//   frame_bad   1-cycle strobe on the stop-bit sample cycle, stop bit low
// ---------------------------------------------------------------------------
module uart_bit_sampler #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       frame_good,
  output logic       frame_bad
);
  import uart_cmd_pkg::*;

  localparam int             TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  logic          rxd_meta_reg;
  logic          rxd_sync_reg;
  rx_state_t     state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  // Set after a frame error so a held-low line (break) is not mistaken for
  // an endless stream of start bits; cleared once the line is seen high.
  logic          wait_high_reg, wait_high_next;
  logic          bit_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_reg  <= 1'b1;
      rxd_sync_reg  <= 1'b1;
      state_reg     <= IDLE;
      timer_reg     <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      wait_high_reg <= 1'b0;
    end else begin
      rxd_meta_reg  <= rxd;
      rxd_sync_reg  <= rxd_meta_reg;
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      wait_high_reg <= wait_high_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    wait_high_next = wait_high_reg;
    frame_good     = 1'b0;
    frame_bad      = 1'b0;
    bit_end        = (timer_reg == BIT_END);

    case (state_reg)
      IDLE: begin
        timer_next   = '0;
        bit_idx_next = '0;
        if (wait_high_reg) begin
          if (rxd_sync_reg) wait_high_next = 1'b0;
        end else if (!rxd_sync_reg) begin
          state_next = START;
        end
      end

      START: begin
        if (timer_reg == HALF_END) begin
          timer_next = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_next = rxd_sync_reg ? IDLE : DATA;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          timer_next   = '0;
          shift_next   = {rxd_sync_reg, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          timer_next = '0;
          state_next = IDLE;
          if (rxd_sync_reg) begin
            frame_good = 1'b1;
          end else begin
            frame_bad      = 1'b1;
            wait_high_next = 1'b1;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign rx_byte = shift_reg;

endmodule

// File: rtl/uart_cmd_receiver.sv
// ---------------------------------------------------------------------------
// uart_cmd_receiver
// UART command receiver: serial byte recovery plus a single-entry output
// buffer with valid/ready handshake. The receiver never stalls; a byte that
// completes while the previous one is still pending overwrites it.
//
// Optional feature (macro UART_CMD_FILTER_EN): only 'T' (8'h54) and
// 'D' (8'h44) are delivered; other good frames pulse cmd_reject and leave
// the buffer untouched. Without the macro every good frame is delivered and
// cmd_reject stays 0.
//
// Parameters:
//   CLKS_PER_BIT   clk cycles per UART bit (>= 4)
// Ports:
//   clk            system clock, posedge
//   rst            asynchronous reset, active low
//   uart_rxd       serial line, 8N1, idle high
//   ready_to_act   consumer ready; transfer when valid_command && ready_to_act
//   uart_rx        pending command byte
//   valid_command  command byte pending
//   frame_error    1-cycle pulse, stop bit sampled low
//   overrun        1-cycle pulse, pending byte overwritten
//   cmd_reject     1-cycle pulse, good frame dropped by the filter
// ---------------------------------------------------------------------------
module uart_cmd_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       ready_to_act,
  output logic [7:0] uart_rx,
  output logic       valid_command,
  output logic       frame_error,
  output logic       overrun,
  output logic       cmd_reject
);
  import uart_cmd_pkg::*;

  logic [7:0] rx_byte;
  logic       frame_good;
  logic       frame_bad;
  logic       accept;
  logic       reject;
  logic       transfer;

  uart_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rxd        (uart_rxd),
    .rx_byte    (rx_byte),
    .frame_good (frame_good),
    .frame_bad  (frame_bad)
  );

`ifdef UART_CMD_FILTER_EN
  assign accept = frame_good &&  is_command(rx_byte);
  assign reject = frame_good && !is_command(rx_byte);
`else
  assign accept = frame_good;
  assign reject = 1'b0;
`endif

  assign transfer = valid_command && ready_to_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_rx       <= 8'h00;
      valid_command <= 1'b0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
      cmd_reject    <= 1'b0;
    end else begin
      frame_error <= frame_bad;
      cmd_reject  <= reject;
      // A byte consumed on the same cycle a new one lands is not an overrun.
      overrun     <= accept && valid_command && !ready_to_act;
      if (accept) begin
        uart_rx       <= rx_byte;
        valid_command <= 1'b1;
      end else if (transfer) begin
        valid_command <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_receiver
// Self-checking bench for uart_cmd_receiver with CLKS_PER_BIT = 16.
// Inputs change 1 time unit after posedge; outputs are observed on negedge.
// Compile with +define+UART_CMD_FILTER_EN to check the filtered build.
// ---------------------------------------------------------------------------
module tb_uart_cmd_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       ready_to_act = 1'b0;
  logic [7:0] uart_rx;
  logic       valid_command;
  logic       frame_error;
  logic       overrun;
  logic       cmd_reject;

  uart_cmd_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rxd      (uart_rxd),
    .ready_to_act  (ready_to_act),
    .uart_rx       (uart_rx),
    .valid_command (valid_command),
    .frame_error   (frame_error),
    .overrun       (overrun),
    .cmd_reject    (cmd_reject)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: free-running event counters, never cleared.
  logic [7:0] got_q[$];
  int err_cnt = 0, ovr_cnt = 0, rej_cnt = 0, vhi_cnt = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (valid_command && ready_to_act) got_q.push_back(uart_rx);
    if (frame_error) err_cnt++;
    if (overrun)     ovr_cnt++;
    if (cmd_reject)  rej_cnt++;
    if (valid_command) vhi_cnt++;
    if (valid_command && !prev_valid) rise_cyc = cyc;
    prev_valid = valid_command;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int base_got, base_err, base_ovr, base_rej, base_vhi;
  int start_cyc;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) ready_to_act = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic mark();
    base_got = got_q.size();
    base_err = err_cnt;
    base_ovr = ovr_cnt;
    base_rej = rej_cnt;
    base_vhi = vhi_cnt;
  endtask

  function automatic int last_byte();
    return (got_q.size() > base_got) ? int'(got_q[$]) : -1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    start_cyc = cyc;
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stop_ok;
    tick(CPB);
    uart_rxd = 1'b1;
  endtask

  // Reference rule for which good frames reach the consumer.
  function automatic bit model_accepts(input logic [7:0] b);
`ifdef UART_CMD_FILTER_EN
    return (b == 8'h54) || (b == 8'h44);
`else
    return 1'b1;
`endif
  endfunction

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_deliver;
    int         exp_err;
    int         exp_rej;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] exp_q[$];

  initial begin
    int exp_err_r, exp_rej_r, bad, d, rg_base;
    logic [7:0] b;
    bit ok;

    vecs[0].data = 8'h54; vecs[0].stop_ok = 1'b1;
    vecs[1].data = 8'h44; vecs[1].stop_ok = 1'b1;
    vecs[2].data = 8'h41; vecs[2].stop_ok = 1'b1;
    vecs[3].data = 8'h54; vecs[3].stop_ok = 1'b0;
    vecs[4].data = 8'h0D; vecs[4].stop_ok = 1'b1;
    vecs[5].data = 8'hA5; vecs[5].stop_ok = 1'b1;
    foreach (vecs[i]) begin
      vecs[i].exp_deliver = int'(vecs[i].stop_ok && model_accepts(vecs[i].data));
      vecs[i].exp_err     = int'(!vecs[i].stop_ok);
      vecs[i].exp_rej     = int'(vecs[i].stop_ok && !model_accepts(vecs[i].data));
    end

    // Reset state
    tick(3);
    check("rst_valid", int'(valid_command), 0);
    check("rst_uart_rx", int'(uart_rx), 0);
    check("rst_frame_error", int'(frame_error), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_cmd_reject", int'(cmd_reject), 0);
    rst = 1'b1;
    tick(CPB);

    // Table-driven single frames, consumer always ready
    ready_to_act = 1'b1;
    foreach (vecs[i]) begin
      mark();
      send_frame(vecs[i].data, vecs[i].stop_ok);
      tick(2 * CPB);
      $display("vec %0d: byte %02h stop_ok %0d delivered %0d", i, vecs[i].data,
               vecs[i].stop_ok, got_q.size() - base_got);
      check($sformatf("vec%0d_deliver", i), got_q.size() - base_got, vecs[i].exp_deliver);
      check($sformatf("vec%0d_valid_cycles", i), vhi_cnt - base_vhi, vecs[i].exp_deliver);
      check($sformatf("vec%0d_frame_error", i), err_cnt - base_err, vecs[i].exp_err);
      check($sformatf("vec%0d_cmd_reject", i), rej_cnt - base_rej, vecs[i].exp_rej);
      check($sformatf("vec%0d_overrun", i), ovr_cnt - base_ovr, 0);
      if (vecs[i].exp_deliver != 0) begin
        check($sformatf("vec%0d_data", i), last_byte(), int'(vecs[i].data));
        // Stop bit centre lands 9.5 bit times after the start edge; allow
        // synchronizer and output latency up to the end of the stop bit.
        d = rise_cyc - start_cyc;
        check($sformatf("vec%0d_latency_window", i),
              int'(d >= (CPB * 19) / 2 && d <= CPB * 10), 1);
      end
    end

    // Consumer holds off for 100 cycles
    ready_to_act = 1'b0;
    mark();
    send_frame(8'h44, 1'b1);
    tick(4);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(valid_command === 1'b1 && uart_rx === 8'h44)) bad++;
    end
    check("hold_stable_cycles_bad", bad, 0);
    @(posedge clk); #1;
    ready_to_act = 1'b1;
    @(negedge clk);
    check("hold_valid_at_ready", int'(valid_command), 1);
    @(negedge clk);
    check("hold_valid_after_xfer", int'(valid_command), 0);
    check("hold_delivered", got_q.size() - base_got, 1);
    check("hold_data", last_byte(), 8'h44);
    $display("hold: byte 44 delivered after ready");
    tick(CPB);

    // Short low glitch on an idle line
    mark();
    uart_rxd = 1'b0;
    tick(5);
    uart_rxd = 1'b1;
    tick(2 * CPB);
    check("glitch_any_output", (got_q.size() - base_got) + (err_cnt - base_err)
          + (rej_cnt - base_rej) + (vhi_cnt - base_vhi), 0);
    send_frame(8'h44, 1'b1);
    tick(2 * CPB);
    check("glitch_next_delivered", got_q.size() - base_got, 1);
    check("glitch_next_data", last_byte(), 8'h44);
    $display("glitch: 5-cycle pulse ignored, next byte 44 received");

    // Break: line held low for many bit times
    mark();
    uart_rxd = 1'b0;
    tick(30 * CPB);
    check("break_frame_errors", err_cnt - base_err, 1);
    uart_rxd = 1'b1;
    tick(CPB);
    send_frame(8'h44, 1'b1);
    tick(2 * CPB);
    check("break_recover_data", last_byte(), 8'h44);
    check("break_frame_errors_total", err_cnt - base_err, 1);
    $display("break: one frame error, then byte 44 received");

    // Overrun, then reset in the middle of a third frame
    ready_to_act = 1'b0;
    mark();
    send_frame(8'h54, 1'b1);
    tick(CPB);
    send_frame(8'h44, 1'b1);
    tick(4);
    check("ovr_pulses", ovr_cnt - base_ovr, 1);
    check("ovr_valid", int'(valid_command), 1);
    check("ovr_data", int'(uart_rx), 8'h44);
    uart_rxd = 1'b0;
    tick(3 * CPB);
    rst = 1'b0;
    uart_rxd = 1'b1;
    tick(2);
    check("midrst_outputs", {24'd0, uart_rx} + int'(valid_command) + int'(frame_error)
          + int'(overrun) + int'(cmd_reject), 0);
    rst = 1'b1;
    ready_to_act = 1'b1;
    tick(12 * CPB);
    check("midrst_no_delivery", got_q.size() - base_got, 0);
    check("midrst_no_error", err_cnt - base_err, 0);
    check("midrst_valid", int'(valid_command), 0);
    $display("overrun: byte 44 overwrote 54; reset aborted third frame");

    // Randomized frames with random consumer readiness
    mark();
    rg_base = got_q.size();
    exp_err_r = 0;
    exp_rej_r = 0;
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      b  = ($urandom_range(0, 1) != 0) ? (($urandom_range(0, 1) != 0) ? 8'h54 : 8'h44)
                                       : 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      if (!ok) exp_err_r++;
      else if (model_accepts(b)) exp_q.push_back(b);
      else exp_rej_r++;
      send_frame(b, ok);
      tick($urandom_range(4, 40));
      $display("rand %0d: byte %02h stop_ok %0d", n, b, ok);
    end
    rand_ready = 1'b0;
    ready_to_act = 1'b1;
    tick(3 * CPB);
    check("rand_count", got_q.size() - rg_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && rg_base + i < got_q.size(); i++)
      check($sformatf("rand_byte%0d", i), int'(got_q[rg_base + i]), int'(exp_q[i]));
    check("rand_frame_errors", err_cnt - base_err, exp_err_r);
    check("rand_rejects", rej_cnt - base_rej, exp_rej_r);
    check("rand_overruns", ovr_cnt - base_ovr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
